// File: rtl/data_memory_pipe.sv
// Byte-enabled 32-bit data memory with a fixed 1- or 2-cycle ack pipeline.
// Optional out-of-range detection is enabled by defining DATA_MEMORY_PIPE_RANGE_CHECK_EN.
module data_memory_pipe #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        error
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [33:0] SPAN  = 34'(DEPTH) << 2;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("data_memory_pipe: READ_LATENCY must be 1 or 2");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
    $error("data_memory_pipe: ADDR_BITS must be in 1..30");
  end
  if ((34'(BASE_ADDR) & (SPAN - 34'd1)) != 34'd0) begin : g_bad_base
    $error("data_memory_pipe: BASE_ADDR must be aligned to the memory span");
  end

  logic [31:0]          offset;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 in_range;
  logic                 accept;
  logic                 do_write;
  logic                 unused_offset;

  always_comb begin
    offset   = address - BASE_ADDR;
    word_idx = offset[ADDR_BITS+1:2];
`ifdef DATA_MEMORY_PIPE_RANGE_CHECK_EN
    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
    in_range = ({2'b00, offset} < SPAN);
`else
    in_range = 1'b1;
`endif
    accept   = request & reset_n;
    do_write = accept & write & in_range;
  end

  assign unused_offset = ^offset;

  logic [31:0] ram_q [DEPTH];

  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) ram_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage p1: registered at the accepting edge (RAM read happens here)
  logic        vld_p1_d, vld_p1_q;
  logic        wr_p1_d,  wr_p1_q;
  logic        err_p1_d, err_p1_q;
  logic [31:0] rdata_p1_d, rdata_p1_q;

  always_comb begin
    vld_p1_d   = accept;
    wr_p1_d    = write;
    err_p1_d   = ~in_range;
    rdata_p1_d = ram_q[word_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      wr_p1_q  <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      wr_p1_q  <= wr_p1_d;
      err_p1_q <= err_p1_d;
    end
  end

  always_ff @(posedge clock) begin
    rdata_p1_q <= rdata_p1_d;
  end

  logic        vld_out;
  logic        wr_out;
  logic        err_out;
  logic [31:0] data_out;

  if (READ_LATENCY == 2) begin : g_lat2
    // Stage p2: output register after the RAM
    logic        vld_p2_d, vld_p2_q;
    logic        wr_p2_d,  wr_p2_q;
    logic        err_p2_d, err_p2_q;
    logic [31:0] rdata_p2_d, rdata_p2_q;

    always_comb begin
      vld_p2_d   = vld_p1_q;
      wr_p2_d    = wr_p1_q;
      err_p2_d   = err_p1_q;
      rdata_p2_d = rdata_p1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_p2_q <= 1'b0;
        wr_p2_q  <= 1'b0;
        err_p2_q <= 1'b0;
      end else begin
        vld_p2_q <= vld_p2_d;
        wr_p2_q  <= wr_p2_d;
        err_p2_q <= err_p2_d;
      end
    end

    always_ff @(posedge clock) begin
      rdata_p2_q <= rdata_p2_d;
    end

    assign vld_out  = vld_p2_q;
    assign wr_out   = wr_p2_q;
    assign err_out  = err_p2_q;
    assign data_out = rdata_p2_q;
  end else begin : g_lat1
    assign vld_out  = vld_p1_q;
    assign wr_out   = wr_p1_q;
    assign err_out  = err_p1_q;
    assign data_out = rdata_p1_q;
  end

  // Data registers are never reset; gating by the valid bit keeps outputs clean.
  always_comb begin
    ack   = vld_out;
    error = vld_out & err_out;
    rdata = (vld_out && !wr_out && !err_out) ? data_out : 32'h0;
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: a LAT=1 instance driven from a vector table and a
// LAT=2 instance (BASE_ADDR=0x1000) driven by hand sequences, both scoreboarded.
module tb_data_memory_pipe;

`ifdef DATA_MEMORY_PIPE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
  localparam int NV   = 19;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        wr    [2];
  logic [3:0]  strb  [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        ak    [2];
  logic        er    [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  exp_t sbq[$];
  vec_t vt [NV];

  data_memory_pipe #(.ADDR_BITS(10), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(LAT0)) u_lat1 (
    .clock(clk), .reset_n(rst_n[0]), .request(req[0]), .address(addr[0]), .write(wr[0]),
    .wstrb(strb[0]), .wdata(wd[0]), .rdata(rd[0]), .ack(ak[0]), .error(er[0])
  );

  data_memory_pipe #(.ADDR_BITS(10), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(LAT1)) u_lat2 (
    .clock(clk), .reset_n(rst_n[1]), .request(req[1]), .address(addr[1]), .write(wr[1]),
    .wstrb(strb[1]), .wdata(wd[1]), .rdata(rd[1]), .ack(ak[1]), .error(er[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations on ack, checks quiet outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        while (sbq.size() != 0 && sbq[0].dut == d) void'(sbq.pop_front());
      end
      if (ak[d]) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          chk($sformatf("dut%0d_spurious_ack", d), 32'(ak[d]), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.due));
          chk($sformatf("dut%0d_rdata", d), rd[d], e.rd);
          chk($sformatf("dut%0d_error", d), 32'(er[d]), 32'(e.err));
        end
      end else begin
        chk($sformatf("dut%0d_idle_rdata", d), rd[d], 32'h0);
        chk($sformatf("dut%0d_idle_error", d), 32'(er[d]), 32'd0);
        if (sbq.size() != 0 && sbq[0].dut == d && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          chk($sformatf("dut%0d_missing_ack", d), 32'(ak[d]), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dat, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    req[d]  = 1'b1;
    wr[d]   = w;
    addr[d] = a;
    strb[d] = s;
    wd[d]   = dat;
    e.dut = d;
    e.due = cyc + ((d == 0) ? LAT0 : LAT1);
    e.rd  = exp_rd;
    e.err = exp_err;
    sbq.push_back(e);
    step();
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    wr[d]  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h20,   4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h30,   4'hF, 32'h00000001, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h30,   4'h0, 32'h0,        32'h00000001, 1'b0};
    vt[7]  = '{1'b1, 32'h40,   4'hF, 32'h12345678, 32'h0,        1'b0};
    vt[8]  = '{1'b1, 32'h40,   4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h40,   4'h0, 32'h0,        32'h12345678, 1'b0};
    vt[10] = '{1'b0, 32'h13,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[11] = '{1'b1, 32'h10,   4'h1, 32'h000000AA, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
    vt[13] = '{1'b1, 32'h1010, 4'hF, 32'hFFFFFFFF, 32'h0,        RC};
    vt[14] = '{1'b0, 32'h1010, 4'h0, 32'h0,        RC ? 32'h0 : 32'hFFFFFFFF, RC};
    vt[15] = '{1'b0, 32'h10,   4'h0, 32'h0,        RC ? 32'hDEADBEAA : 32'hFFFFFFFF, 1'b0};
    vt[16] = '{1'b0, 32'h30,   4'h0, 32'h0,        32'h00000001, 1'b0};
    vt[17] = '{1'b1, 32'h30,   4'hF, 32'h00000002, 32'h0,        1'b0};
    vt[18] = '{1'b0, 32'h30,   4'h0, 32'h0,        32'h00000002, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req[d]   = 1'b0;
      wr[d]    = 1'b0;
      addr[d]  = 32'h0;
      strb[d]  = 4'h0;
      wd[d]    = 32'h0;
    end
    repeat (3) step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(0, vt[i].w, vt[i].a, vt[i].s, vt[i].d, vt[i].exp_rd, vt[i].exp_err);
    end
    idle(0, 3);

    issue(1, 1'b1, 32'h1000, 4'hF, 32'h000000A0, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h1004, 4'hF, 32'h00000055, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h1008, 4'hF, 32'h00000066, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h000000A0, 1'b0);
    issue(1, 1'b0, 32'h1004, 4'h0, 32'h0, 32'h00000055, 1'b0);
    issue(1, 1'b0, 32'h1008, 4'h0, 32'h0, 32'h00000066, 1'b0);
    idle(1, 3);

    issue(1, 1'b0, 32'h1004, 4'h0, 32'h0, 32'h00000055, 1'b0);
    issue(1, 1'b1, 32'h1004, 4'hF, 32'h00000099, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h1004, 4'h0, 32'h0, 32'h00000099, 1'b0);
    idle(1, 2);

    issue(1, 1'b1, 32'h1000, 4'hF, 32'h12340000, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h2000, 4'hF, 32'hFFFFFFFF, 32'h0, RC);
    issue(1, 1'b0, 32'h1000, 4'h0, 32'h0, RC ? 32'h12340000 : 32'hFFFFFFFF, 1'b0);
    idle(1, 2);

    issue(1, 1'b1, 32'h1008, 4'hF, 32'h00000077, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h1004, 4'h0, 32'h0, 32'h00000099, 1'b0);
    req[1]   = 1'b0;
    rst_n[1] = 1'b0;
    step();
    rst_n[1] = 1'b1;
    idle(1, 3);
    issue(1, 1'b0, 32'h1008, 4'h0, 32'h0, 32'h00000077, 1'b0);
    issue(1, 1'b0, 32'h1004, 4'h0, 32'h0, 32'h00000099, 1'b0);
    idle(1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
